// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single register-file write port between the ALU (single-cycle
// producer) and the memory/load unit (multicycle producer). The winning
// request is registered into a one-cycle output stage that drives the
// register file. A 32-entry pending-write scoreboard tracks in-flight
// destinations so issue logic can stall on RAW hazards.
//
// Build option:
//   WB_ROUND_ROBIN_EN  defined   : strict round-robin between the two sources
//                      undefined : mem has priority; the ALU is force-granted
//                                  after STARVE_LIMIT consecutive losses
//
// Parameters:
//   XLEN          data width of write_data and both source data buses
//   STARVE_LIMIT  consecutive ALU losses before a forced grant (1..15)
//
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   alu_valid/rd/data       ALU writeback request,    alu_ready accept
//   mem_valid/rd/data       memory writeback request, mem_ready accept
//   issue_valid, issue_rd   issuing instruction marks its destination pending
//   rs1, rs2 -> busy1, busy2  combinational scoreboard queries
//   reg_write, rd, write_data registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            busy1,
    output logic            busy2,
    output logic            reg_write,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] write_data
);

    logic            alu_grant;
    logic            mem_grant;
    logic            xfer_p0;
    logic [4:0]      rd_p0;
    logic [XLEN-1:0] data_p0;

    logic            vld_p1;
    logic [4:0]      rd_p1;
    logic [XLEN-1:0] data_p1;

    logic [31:0]     pending;
    logic [31:0]     pending_nxt;

    // ---- stage p0: arbitration (combinational from valids and state) ----
`ifdef WB_ROUND_ROBIN_EN
    // rr_last: 0 = ALU was granted last, 1 = mem was granted last.
    logic rr_last;

    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (alu_valid && mem_valid) begin
            if (rr_last) begin
                alu_grant = 1'b1;
            end else begin
                mem_grant = 1'b1;
            end
        end else begin
            alu_grant = alu_valid;
            mem_grant = mem_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last <= 1'b0;
        end else if (alu_grant) begin
            rr_last <= 1'b0;
        end else if (mem_grant) begin
            rr_last <= 1'b1;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt;
    logic       alu_force;

    // Once the ALU has lost STARVE_LIMIT times in a row it wins outright.
    assign alu_force = alu_valid && (starve_cnt == STARVE_MAX);

    always_comb begin
        alu_grant = alu_valid && (alu_force || !mem_valid);
        mem_grant = mem_valid && !alu_force;
    end

    // An ALU request that is not granted here has necessarily lost to mem.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= 4'd0;
        end else if (!alu_valid || alu_grant) begin
            starve_cnt <= 4'd0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    assign alu_ready = alu_grant;
    assign mem_ready = mem_grant;

    assign xfer_p0 = alu_grant || mem_grant;
    assign rd_p0   = alu_grant ? alu_rd   : mem_rd;
    assign data_p0 = alu_grant ? alu_data : mem_data;

    // ---- stage p1: registered register-file write port ----
    // A granted write to x0 still updates rd/write_data but never asserts
    // reg_write, so it cannot touch the scoreboard either.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            rd_p1   <= 5'd0;
            data_p1 <= '0;
        end else begin
            vld_p1 <= xfer_p0 && (rd_p0 != 5'd0);
            if (xfer_p0) begin
                rd_p1   <= rd_p0;
                data_p1 <= data_p0;
            end
        end
    end

    assign reg_write  = vld_p1;
    assign rd         = rd_p1;
    assign write_data = data_p1;

    // ---- scoreboard: clear on commit, set on issue (set applied last wins) ----
    always_comb begin
        pending_nxt = pending;
        if (vld_p1) begin
            pending_nxt[rd_p1] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 32'd0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // No bypass from the committing write: busy drops the cycle after reg_write.
    assign busy1 = pending[rs1];
    assign busy2 = pending[rs2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            mem_valid;
    logic [4:0]      mem_rd;
    logic [XLEN-1:0] mem_data;
    logic            mem_ready;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            busy1;
    logic            busy2;
    logic            reg_write;
    logic [4:0]      rd;
    logic [XLEN-1:0] write_data;

    int checks = 0;
    int errors = 0;

    regfile_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .busy1       (busy1),
        .busy2       (busy2),
        .reg_write   (reg_write),
        .rd          (rd),
        .write_data  (write_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_alu;

        reset       = 1'b1;
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = '0;
        mem_valid   = 1'b0;
        mem_rd      = 5'd0;
        mem_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd1;
        rs2         = 5'd2;

        step();
        step();
        check("rst_reg_write", 64'(reg_write), 64'd0);
        check("rst_rd", 64'(rd), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_busy2", 64'(busy2), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);

        reset = 1'b0;
        step();

        // Single ALU write, latency 1.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEADBEEF;
        #1;
        check("t1_alu_ready", 64'(alu_ready), 64'd1);
        check("t1_mem_ready", 64'(mem_ready), 64'd0);
        step();
        alu_valid = 1'b0;
        #1;
        check("t1_reg_write", 64'(reg_write), 64'd1);
        check("t1_rd", 64'(rd), 64'd5);
        check("t1_write_data", 64'(write_data), 64'hDEADBEEF);
        step();
        check("t1_idle_reg_write", 64'(reg_write), 64'd0);
        check("t1_hold_rd", 64'(rd), 64'd5);
        check("t1_hold_data", 64'(write_data), 64'hDEADBEEF);

        // Both sources valid continuously.
        alu_valid = 1'b1;
        alu_rd    = 5'd3;
        alu_data  = 32'h0000_00A3;
        mem_valid = 1'b1;
        mem_rd    = 5'd4;
        mem_data  = 32'h0000_00B4;
        for (int i = 0; i < 10; i++) begin
`ifdef WB_ROUND_ROBIN_EN
            exp_alu = (i % 2) == 1;
`else
            exp_alu = (i % 5) == 4;
`endif
            #1;
            check($sformatf("arb_alu_ready_%0d", i), 64'(alu_ready), 64'(exp_alu));
            check($sformatf("arb_mem_ready_%0d", i), 64'(mem_ready), 64'(!exp_alu));
            step();
            check($sformatf("arb_rd_%0d", i), 64'(rd), exp_alu ? 64'd3 : 64'd4);
            check($sformatf("arb_data_%0d", i), 64'(write_data),
                  exp_alu ? 64'h0000_00A3 : 64'h0000_00B4);
            check($sformatf("arb_reg_write_%0d", i), 64'(reg_write), 64'd1);
        end
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        step();

        // Scoreboard set on issue, cleared the cycle after commit.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        rs1         = 5'd7;
        #1;
        check("sb7_busy_before", 64'(busy1), 64'd0);
        step();
        issue_valid = 1'b0;
        #1;
        check("sb7_busy_set", 64'(busy1), 64'd1);
        mem_valid = 1'b1;
        mem_rd    = 5'd7;
        mem_data  = 32'h0000_0077;
        #1;
        check("sb7_mem_ready", 64'(mem_ready), 64'd1);
        step();
        mem_valid = 1'b0;
        #1;
        check("sb7_reg_write", 64'(reg_write), 64'd1);
        check("sb7_rd", 64'(rd), 64'd7);
        check("sb7_busy_during_commit", 64'(busy1), 64'd1);
        step();
        check("sb7_busy_cleared", 64'(busy1), 64'd0);
        check("sb7_reg_write_low", 64'(reg_write), 64'd0);

        // Set and clear of the same entry in one cycle: set wins.
        issue_valid = 1'b1;
        issue_rd    = 5'd9;
        mem_valid   = 1'b1;
        mem_rd      = 5'd9;
        mem_data    = 32'h0000_0099;
        rs2         = 5'd9;
        step();
        mem_valid = 1'b0;
        #1;
        check("sb9_busy_set", 64'(busy2), 64'd1);
        check("sb9_reg_write", 64'(reg_write), 64'd1);
        check("sb9_rd", 64'(rd), 64'd9);
        step();
        issue_valid = 1'b0;
        #1;
        check("sb9_set_wins", 64'(busy2), 64'd1);
        check("sb9_reg_write_low", 64'(reg_write), 64'd0);

        // Build pending = 0x0F00 with a write in flight, then reset asynchronously.
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        step();
        issue_rd = 5'd10;
        step();
        issue_rd  = 5'd11;
        alu_valid = 1'b1;
        alu_rd    = 5'd12;
        alu_data  = 32'h0000_0C0C;
        step();
        issue_valid = 1'b0;
        alu_valid   = 1'b0;
        rs1         = 5'd8;
        rs2         = 5'd11;
        #1;
        check("pre_rst_reg_write", 64'(reg_write), 64'd1);
        check("pre_rst_busy1", 64'(busy1), 64'd1);
        check("pre_rst_busy2", 64'(busy2), 64'd1);
        reset = 1'b1;
        #1;
        check("async_rst_reg_write", 64'(reg_write), 64'd0);
        check("async_rst_busy1", 64'(busy1), 64'd0);
        check("async_rst_busy2", 64'(busy2), 64'd0);
        check("async_rst_rd", 64'(rd), 64'd0);
        step();
        reset = 1'b0;
        step();

        // Write to x0 and issue to x0: handshake only, no reg_write, no busy.
        alu_valid   = 1'b1;
        alu_rd      = 5'd0;
        alu_data    = 32'h0000_1234;
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        #1;
        check("x0_alu_ready", 64'(alu_ready), 64'd1);
        step();
        alu_valid   = 1'b0;
        issue_valid = 1'b0;
        #1;
        check("x0_reg_write", 64'(reg_write), 64'd0);
        check("x0_busy1", 64'(busy1), 64'd0);
        check("x0_write_data", 64'(write_data), 64'h0000_1234);
        step();
        check("x0_busy1_later", 64'(busy1), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
